eq_coeff_ctrl: RTL and testbench

EQ_COEFF_CTRL -- requirements
Module: eq_coeff_ctrl

---
 rtl/eq_coeff_ctrl.sv | 137 +++++++++++++
 tb/tb_eq_coeff_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_ctrl.sv
`default_nettype none
// ============================================================================
// eq_coeff_ctrl : double-buffered equalizer coefficient store, frame-aligned swap
// Revision      : 1.0
// ============================================================================
module eq_coeff_ctrl #(
  parameter  int NR_CHANNELS    = 3,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int N              = NR_CHANNELS * NR_EQ_BANDS * 5,
  localparam int AW             = $clog2(N),
  localparam int CW             = $clog2(NR_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [EQ_COEFF_WIDTH-1:0] cfg_wdata,
  input  logic [AW-1:0]             cfg_waddr,
  input  logic                      cfg_wvalid,
  output logic                      cfg_wready,
  input  logic                      cfg_commit,
  output logic                      cfg_busy,
  output logic                      cfg_error,
  output logic                      swap_done,
  output logic                      bank_sel,
  input  logic [AW-1:0]             eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic [CW-1:0]             s_tid
);

  localparam logic [AW-1:0]             LAST  = AW'(N - 1);
  localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = {3'b000, 1'b1, {(EQ_COEFF_WIDTH-4){1'b0}}};

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    PENDING = 2'd2,
    COPY    = 2'd3
  } state_t;

  state_t                    state, next_state;
  logic [AW-1:0]             cnt;
  logic [2:0]                phase;
  logic [EQ_COEFF_WIDTH-1:0] bank0 [0:N-1];
  logic [EQ_COEFF_WIDTH-1:0] bank1 [0:N-1];
  logic                      mem_we0, mem_we1;
  logic [AW-1:0]             mem_waddr;
  logic [EQ_COEFF_WIDTH-1:0] mem_wdata;
  logic [EQ_COEFF_WIDTH-1:0] copy_word;
  logic                      swap, err_next, boundary;
  logic                      waddr_ok, raddr_ok;

  assign boundary = s_tvalid & s_tready & (s_tid == CW'(NR_CHANNELS - 1));
  assign waddr_ok = ({1'b0, cfg_waddr} < (AW+1)'(N));
  assign raddr_ok = ({1'b0, eq_coeff_addr} < (AW+1)'(N));
  assign copy_word = bank_sel ? bank1[cnt] : bank0[cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Shadow bank is always ~bank_sel, so its write enable follows bank_sel directly.
  always_comb begin
    next_state = state;
    mem_we0    = 1'b0;
    mem_we1    = 1'b0;
    mem_waddr  = cnt;
    mem_wdata  = copy_word;
    swap       = 1'b0;
    err_next   = cfg_commit & (state != IDLE);
    cfg_wready = (state == IDLE);
    cfg_busy   = (state != IDLE);
    case (state)
      INIT: begin
        mem_we0   = 1'b1;
        mem_we1   = 1'b1;
        mem_wdata = (phase == 3'd0) ? UNITY : '0;
        if (cnt == LAST) next_state = IDLE;
      end
      IDLE: begin
        if (cfg_wvalid) begin
          if (waddr_ok) begin
            mem_we0   = bank_sel;
            mem_we1   = ~bank_sel;
            mem_waddr = cfg_waddr;
            mem_wdata = cfg_wdata;
          end else begin
            err_next = 1'b1;
          end
        end
        if (cfg_commit) next_state = PENDING;
      end
      PENDING: begin
        if (boundary) begin
          swap       = 1'b1;
          next_state = COPY;
        end
      end
      COPY: begin
        mem_we0 = bank_sel;
        mem_we1 = ~bank_sel;
        if (cnt == LAST) next_state = IDLE;
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      phase     <= 3'd0;
      bank_sel  <= 1'b0;
      swap_done <= 1'b0;
      cfg_error <= 1'b0;
      eq_coeff  <= '0;
    end else begin
      if (state == INIT || state == COPY) cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
      else                                cnt <= '0;
      if (state == INIT) phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
      else               phase <= 3'd0;
      bank_sel  <= bank_sel ^ swap;
      swap_done <= swap;
      cfg_error <= err_next;
      if (state == INIT || !raddr_ok) eq_coeff <= '0;
      else eq_coeff <= bank_sel ? bank1[eq_coeff_addr] : bank0[eq_coeff_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we0) bank0[mem_waddr] <= mem_wdata;
    if (mem_we1) bank1[mem_waddr] <= mem_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_eq_coeff_ctrl.sv
`default_nettype none
// ============================================================================
// tb_eq_coeff_ctrl : self-checking bench for eq_coeff_ctrl against a bank model
// Revision         : 1.0
// ============================================================================
module tb_eq_coeff_ctrl;
  localparam int N  = 120;
  localparam int AW = 7;
  localparam int CW = 2;
  localparam logic [31:0] UNITY = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_wdata = '0;
  logic [AW-1:0] cfg_waddr = '0;
  logic          cfg_wvalid = 1'b0;
  logic          cfg_wready;
  logic          cfg_commit = 1'b0;
  logic          cfg_busy, cfg_error, swap_done, bank_sel;
  logic [AW-1:0] eq_coeff_addr = '0;
  logic [31:0]   eq_coeff;
  logic          s_tvalid = 1'b0, s_tready = 1'b0;
  logic [CW-1:0] s_tid = '0;

  eq_coeff_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wdata(cfg_wdata), .cfg_waddr(cfg_waddr),
    .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_error(cfg_error), .swap_done(swap_done),
    .bank_sel(bank_sel), .eq_coeff_addr(eq_coeff_addr), .eq_coeff(eq_coeff),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tid(s_tid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents of what the host sees as active and shadow banks.
  logic [31:0] act_m [N];
  logic [31:0] sh_m  [N];
  logic        mb;

  typedef struct { logic [AW-1:0] addr; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic v; logic r; logic [CW-1:0] tid; logic exp_swap; } bnd_vec_t;
  rd_vec_t  rd_tab [8];
  bnd_vec_t bnd_tab [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      act_m[k] = (k % 5 == 0) ? UNITY : 32'h0;
      sh_m[k]  = act_m[k];
    end
    mb = 1'b0;
  endtask

  task automatic model_swap();
    for (int k = 0; k < N; k++) act_m[k] = sh_m[k];
    mb = ~mb;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cfg_waddr = a; cfg_wdata = d; cfg_wvalid = 1'b1;
    step();
    cfg_wvalid = 1'b0;
    if (int'(a) < N) sh_m[a] = d;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic set_s(input logic v, input logic r, input logic [CW-1:0] t);
    s_tvalid = v; s_tready = r; s_tid = t;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (cfg_busy && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_init(output int n, output logic rd_nonzero);
    n = 0; rd_nonzero = 1'b0;
    eq_coeff_addr = '0;
    while (!cfg_wready && n < 2000) begin
      if (eq_coeff != 32'h0) rd_nonzero = 1'b1;
      step();
      n++;
    end
  endtask

  task automatic check_all(input string nm);
    for (int k = 0; k < N; k++) begin
      eq_coeff_addr = AW'(k);
      step();
      chk(nm, eq_coeff, act_m[k]);
    end
  endtask

  initial begin
    int          n;
    logic        nz, got, b;
    int          nw;
    logic [AW-1:0] ra;
    logic [31:0] rd;

    rd_tab[0] = '{7'd0,   UNITY};
    rd_tab[1] = '{7'd1,   32'h0};
    rd_tab[2] = '{7'd4,   32'h0};
    rd_tab[3] = '{7'd5,   UNITY};
    rd_tab[4] = '{7'd115, UNITY};
    rd_tab[5] = '{7'd119, 32'h0};
    rd_tab[6] = '{7'd120, 32'h0};
    rd_tab[7] = '{7'd127, 32'h0};
    bnd_tab[0] = '{1'b1, 1'b1, 2'd0, 1'b0};
    bnd_tab[1] = '{1'b1, 1'b1, 2'd1, 1'b0};
    bnd_tab[2] = '{1'b1, 1'b0, 2'd2, 1'b0};
    bnd_tab[3] = '{1'b0, 1'b1, 2'd2, 1'b0};
    bnd_tab[4] = '{1'b1, 1'b1, 2'd3, 1'b0};
    bnd_tab[5] = '{1'b1, 1'b1, 2'd2, 1'b1};

    model_reset();
    repeat (3) step();
    chk("rst_busy", cfg_busy, 1);
    chk("rst_wready", cfg_wready, 0);
    chk("rst_bank", bank_sel, 0);
    chk("rst_eq", eq_coeff, 0);
    chk("rst_err", cfg_error, 0);
    chk("rst_swap", swap_done, 0);
    rst = 1'b0;
    wait_init(n, nz);
    chk("init_len", n, N);
    chk("init_rd_zero", nz, 0);
    chk("init_bank", bank_sel, 0);

    for (int i = 0; i < 8; i++) begin
      eq_coeff_addr = rd_tab[i].addr;
      step();
      chk("rd_table", eq_coeff, rd_tab[i].exp);
    end

    // Single-word edit, commit, one qualifying boundary.
    chk("idle_wready", cfg_wready, 1);
    wr(7'd0, 32'h1800_0000);
    commit();
    chk("pend_busy", cfg_busy, 1);
    chk("pend_wready", cfg_wready, 0);
    eq_coeff_addr = 7'd0;
    step();
    chk("pend_rd_old", eq_coeff, UNITY);
    set_s(1, 1, 2'd2);
    step();
    set_s(0, 0, 2'd0);
    model_swap();
    chk("swap_pulse", swap_done, 1);
    chk("swap_bank", bank_sel, mb);
    step();
    chk("swap_single", swap_done, 0);
    wait_idle(n);
    chk("copy_len", n + 1, N);
    check_all("rd_after_swap1");

    // Incremental edit relies on COPY having mirrored the active bank.
    wr(7'd1, 32'h0abc_0000);
    commit();
    set_s(1, 1, 2'd2);
    step();
    set_s(0, 0, 2'd0);
    model_swap();
    chk("swap2_bank", bank_sel, mb);
    wait_idle(n);
    check_all("rd_incremental");

    // Non-qualifying boundaries while pending, then a real one.
    wr(7'd2, 32'h0222_0000);
    commit();
    for (int i = 0; i < 6; i++) begin
      set_s(bnd_tab[i].v, bnd_tab[i].r, bnd_tab[i].tid);
      step();
      if (bnd_tab[i].exp_swap) model_swap();
      chk("bnd_swap", swap_done, bnd_tab[i].exp_swap);
      chk("bnd_bank", bank_sel, mb);
    end
    set_s(0, 0, 2'd0);
    wait_idle(n);
    check_all("rd_after_bnd");

    // Write + commit + boundary in the same cycle; swap waits for next boundary.
    cfg_waddr = 7'd3; cfg_wdata = 32'h0333_0000; cfg_wvalid = 1'b1; cfg_commit = 1'b1;
    set_s(1, 1, 2'd2);
    step();
    cfg_wvalid = 1'b0; cfg_commit = 1'b0;
    sh_m[3] = 32'h0333_0000;
    chk("commit_bnd_noswap", swap_done, 0);
    chk("commit_bnd_busy", cfg_busy, 1);
    step();
    set_s(0, 0, 2'd0);
    model_swap();
    chk("next_bnd_swap", swap_done, 1);
    wait_idle(n);
    check_all("rd_same_cycle");

    // Dropped write and dropped commit.
    wr(7'd120, 32'hdead_beef);
    chk("bad_wr_err", cfg_error, 1);
    step();
    chk("bad_wr_err_clr", cfg_error, 0);
    commit();
    set_s(1, 1, 2'd2);
    step();
    set_s(0, 0, 2'd0);
    model_swap();
    repeat (3) step();
    commit();
    chk("copy_commit_err", cfg_error, 1);
    step();
    chk("copy_commit_err_clr", cfg_error, 0);
    wait_idle(n);
    set_s(1, 1, 2'd2);
    step();
    set_s(0, 0, 2'd0);
    chk("ignored_commit_noswap", swap_done, 0);
    chk("ignored_commit_bank", bank_sel, mb);
    check_all("rd_after_errors");

    // Randomized edits and randomized traffic while pending.
    for (int t = 0; t < 6; t++) begin
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        ra = AW'($urandom_range(0, N - 1));
        rd = $urandom;
        wr(ra, rd);
      end
      cfg_commit = 1'b1;
      set_s(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)));
      step();
      cfg_commit = 1'b0;
      chk("rand_commit_noswap", swap_done, 0);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        set_s(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)));
        b = s_tvalid && s_tready && (s_tid == 2'd2);
        step();
        chk("rand_swap", swap_done, b);
        if (b) got = 1'b1;
      end
      set_s(0, 0, 2'd0);
      chk("rand_swap_seen", got, 1);
      if (got) model_swap();
      chk("rand_bank", bank_sel, mb);
      wait_idle(n);
      check_all("rd_random");
    end

    // Reset in the middle of COPY.
    wr(7'd5, 32'h0555_0000);
    commit();
    set_s(1, 1, 2'd2);
    step();
    set_s(0, 0, 2'd0);
    repeat (60) step();
    chk("mid_copy_busy", cfg_busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_bank", bank_sel, 0);
    chk("async_rst_eq", eq_coeff, 0);
    chk("async_rst_swap", swap_done, 0);
    repeat (2) step();
    chk("rst2_wready", cfg_wready, 0);
    rst = 1'b0;
    model_reset();
    wait_init(n, nz);
    chk("reinit_len", n, N);
    chk("reinit_rd_zero", nz, 0);
    check_all("rd_after_reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
